// File: rtl/decoder_besleyici.sv
`default_nettype none
// decoder_besleyici: 2-entry input queue that feeds an N-bit decoder, either as a whole word
// or as K-bit chunks (most significant first), and collects its result with a bounded wait.
module decoder_besleyici #(
  parameter int N           = 12,
  parameter int K           = 3,
  parameter int ZAMAN_ASIMI = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         giris_gecerli,
  output logic         giris_hazir,
  input  logic         giris_mod,
  input  logic [N-1:0] giris_veri,
  output logic         basla,
  output logic         mod,
  output logic [N-1:0] gelen_veri,
  input  logic [N-1:0] cikan_veri,
  input  logic         bitti,
  output logic [N-1:0] sonuc,
  output logic         sonuc_gecerli,
  output logic         hata
);
  localparam int PARCA = N / K;
  localparam int CW    = (PARCA > 1) ? $clog2(PARCA) : 1;
  localparam int WW    = $clog2(ZAMAN_ASIMI + 1);
  localparam logic [CW-1:0] SON_PARCA = CW'(PARCA - 1);
  localparam logic [WW-1:0] SON_BEKLE = WW'(ZAMAN_ASIMI - 1);

  localparam logic [1:0] BOS    = 2'd0;
  localparam logic [1:0] GONDER = 2'd1;
  localparam logic [1:0] BEKLE  = 2'd2;
  localparam logic [1:0] SONUC  = 2'd3;

  logic [1:0]    durum_q, durum_d;
  logic [N:0]    kuyruk0_q, kuyruk0_d;
  logic [N:0]    kuyruk1_q, kuyruk1_d;
  logic [1:0]    sayi_q, sayi_d;
  logic          hazir_q, hazir_d;
  logic [N-1:0]  kelime_q, kelime_d;
  logic          mod_q, mod_d;
  logic [CW-1:0] parca_q, parca_d;
  logic [WW-1:0] bekle_q, bekle_d;
  logic [N-1:0]  sonuc_q, sonuc_d;
  logic          hata_q, hata_d;
  logic          push, pop;

  assign push = giris_gecerli && hazir_q;
  assign pop  = (durum_q == BOS) && (sayi_q != 2'd0);

  // Entry 0 is always the head; a pop shifts entry 1 down before any push lands.
  always_comb begin
    kuyruk0_d = kuyruk0_q;
    kuyruk1_d = kuyruk1_q;
    sayi_d    = sayi_q;
    if (pop) begin
      kuyruk0_d = kuyruk1_q;
      sayi_d    = sayi_q - 2'd1;
    end
    if (push) begin
      if (sayi_d == 2'd0) kuyruk0_d = {giris_mod, giris_veri};
      else                kuyruk1_d = {giris_mod, giris_veri};
      sayi_d = sayi_d + 2'd1;
    end
    hazir_d = (sayi_d != 2'd2);
  end

  always_comb begin
    durum_d  = durum_q;
    kelime_d = kelime_q;
    mod_d    = mod_q;
    parca_d  = parca_q;
    bekle_d  = bekle_q;
    sonuc_d  = sonuc_q;
    hata_d   = 1'b0;
    case (durum_q)
      BOS: begin
        if (pop) begin
          kelime_d = kuyruk0_q[N-1:0];
          mod_d    = kuyruk0_q[N];
          parca_d  = '0;
          bekle_d  = '0;
          durum_d  = GONDER;
        end
      end
      GONDER: begin
        if (!mod_q || parca_q == SON_PARCA) begin
          durum_d = BEKLE;
        end else begin
          parca_d  = parca_q + 1'b1;
          kelime_d = kelime_q << K;
        end
      end
      BEKLE: begin
        bekle_d = bekle_q + 1'b1;
        // bitti in the first wait cycle may be left over from the previous word.
        if (bitti && bekle_q != '0) begin
          sonuc_d = cikan_veri;
          durum_d = SONUC;
        end else if (bekle_q == SON_BEKLE) begin
          hata_d  = 1'b1;
          durum_d = BOS;
        end
      end
      default: durum_d = BOS;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      durum_q   <= BOS;
      kuyruk0_q <= '0;
      kuyruk1_q <= '0;
      sayi_q    <= 2'd0;
      hazir_q   <= 1'b0;
      kelime_q  <= '0;
      mod_q     <= 1'b0;
      parca_q   <= '0;
      bekle_q   <= '0;
      sonuc_q   <= '0;
      hata_q    <= 1'b0;
    end else begin
      durum_q   <= durum_d;
      kuyruk0_q <= kuyruk0_d;
      kuyruk1_q <= kuyruk1_d;
      sayi_q    <= sayi_d;
      hazir_q   <= hazir_d;
      kelime_q  <= kelime_d;
      mod_q     <= mod_d;
      parca_q   <= parca_d;
      bekle_q   <= bekle_d;
      sonuc_q   <= sonuc_d;
      hata_q    <= hata_d;
    end
  end

  // In chunked mode the word register shifts left, so the current chunk is always its top K bits.
  assign giris_hazir   = hazir_q;
  assign basla         = (durum_q == GONDER);
  assign mod           = mod_q;
  assign gelen_veri    = !basla ? '0 : (mod_q ? N'(kelime_q[N-1 -: K]) : kelime_q);
  assign sonuc         = sonuc_q;
  assign sonuc_gecerli = (durum_q == SONUC);
  assign hata          = hata_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_besleyici.sv
`default_nettype none
// tb_decoder_besleyici: directed and randomized stimulus for decoder_besleyici, with a decoder
// model and an interface-level reference of the feeder behaviour.
module tb_decoder_besleyici;
  localparam int N     = 12;
  localparam int K     = 3;
  localparam int Z     = 16;
  localparam int PARCA = N / K;

  localparam int M_BOS  = 0;
  localparam int M_SEND = 1;
  localparam int M_WAIT = 2;
  localparam int M_RES  = 3;
  localparam int M_TO   = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         giris_gecerli = 1'b0;
  logic         giris_mod = 1'b0;
  logic [N-1:0] giris_veri = '0;
  logic [N-1:0] cikan_veri = '0;
  logic         bitti = 1'b0;
  logic         giris_hazir, basla, mod, sonuc_gecerli, hata;
  logic [N-1:0] gelen_veri, sonuc;

  int checks = 0;
  int failures = 0;

  logic [N:0] exp_q[$];
  int         lat_q[$];
  int         pushed = 0, popped = 0, n_sonuc = 0, n_hata = 0, kenar = 0;
  bit         keep_stale = 1'b0;
  int         m_st = M_BOS, c = 0, chunk = 0, lat = 0;
  logic [N:0]   cur = '0;
  logic [N-1:0] acc = '0, exp_sonuc = '0, e = '0, tmp = '0;
  logic         exp_mod = 1'b0;

  decoder_besleyici #(.N(N), .K(K), .ZAMAN_ASIMI(Z)) dut (
    .clk(clk), .rst(rst),
    .giris_gecerli(giris_gecerli), .giris_hazir(giris_hazir),
    .giris_mod(giris_mod), .giris_veri(giris_veri),
    .basla(basla), .mod(mod), .gelen_veri(gelen_veri),
    .cikan_veri(cikan_veri), .bitti(bitti),
    .sonuc(sonuc), .sonuc_gecerli(sonuc_gecerli), .hata(hata)
  );

  always #5 clk = ~clk;

  // Stand-in decoder transfer function; known pairs first, otherwise a fixed scramble.
  function automatic logic [N-1:0] dec_f(input logic [N-1:0] x);
    case (x)
      12'h716: return 12'h474;
      12'h01C: return 12'hE19;
      12'hF70: return 12'hD8A;
      12'h39C: return 12'h169;
      default: return {x[5:0], x[11:6]} ^ 12'h5A3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  always @(posedge clk) kenar = rst ? kenar + 1 : 0;

  // Reference of the feeder plus decoder model; evaluated once per cycle at the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk1("rst_basla", basla, 1'b0);
      chk1("rst_hazir", giris_hazir, 1'b0);
      chk1("rst_sgec", sonuc_gecerli, 1'b0);
      chk1("rst_hata", hata, 1'b0);
      chk1("rst_mod", mod, 1'b0);
      chk("rst_sonuc", sonuc, '0);
      m_st = M_BOS; exp_sonuc = '0; exp_mod = 1'b0; bitti = 1'b0; cikan_veri = '0;
    end else begin
      chk1("hazir", giris_hazir, (kenar > 0) && (pushed - popped < 2));
      case (m_st)
        M_BOS, M_TO: begin
          chk1("idle_basla", basla, 1'b0);
          chk1("idle_sgec", sonuc_gecerli, 1'b0);
          chk("sonuc_hold", sonuc, exp_sonuc);
          chk1("mod_hold", mod, exp_mod);
          if (m_st == M_TO) begin
            chk1("hata_pulse", hata, 1'b1);
            n_hata++;
          end else begin
            chk1("hata_idle", hata, 1'b0);
          end
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front(); lat = lat_q.pop_front(); popped++;
            chunk = 0; m_st = M_SEND;
          end else begin
            m_st = M_BOS;
          end
        end
        M_SEND: begin
          chk1("send_basla", basla, 1'b1);
          chk1("send_mod", mod, cur[N]);
          chk1("send_hata", hata, 1'b0);
          if (cur[N]) begin
            tmp = cur[N-1:0] << (K * chunk);
            e   = N'(tmp[N-1 -: K]);
            acc = {acc[N-K-1:0], gelen_veri[K-1:0]};
          end else begin
            e   = cur[N-1:0];
            acc = gelen_veri;
          end
          chk("gelen_veri", gelen_veri, e);
          chunk++;
          if (!cur[N] || chunk == PARCA) begin
            m_st = M_WAIT; c = 1; exp_mod = cur[N];
          end
        end
        M_WAIT: begin
          chk1("wait_basla", basla, 1'b0);
          chk("wait_gelen", gelen_veri, '0);
          chk1("wait_mod", mod, exp_mod);
          chk1("wait_sgec", sonuc_gecerli, 1'b0);
          chk1("wait_hata", hata, 1'b0);
          chk("wait_sonuc", sonuc, exp_sonuc);
          if (c == 1) begin
            if (lat <= 1) begin bitti = 1'b1; cikan_veri = dec_f(acc); end
          end else begin
            bitti = (c >= lat);
            if (bitti) cikan_veri = dec_f(acc);
          end
          if (c >= 2 && bitti) begin
            m_st = M_RES; exp_sonuc = dec_f(cur[N-1:0]);
          end else if (c == Z) begin
            m_st = M_TO;
          end else begin
            c++;
          end
        end
        M_RES: begin
          chk1("res_sgec", sonuc_gecerli, 1'b1);
          chk("res_sonuc", sonuc, exp_sonuc);
          chk1("res_basla", basla, 1'b0);
          chk1("res_hata", hata, 1'b0);
          n_sonuc++;
          if (!keep_stale) bitti = 1'b0;
          m_st = M_BOS;
        end
        default: m_st = M_BOS;
      endcase
    end
  end

  // Offers one word; while stalled the data lines carry garbage that must be ignored.
  task automatic push(input logic m, input logic [N-1:0] w, input int l, output int stall);
    int t = 0;
    giris_gecerli = 1'b1; giris_mod = m; giris_veri = w;
    @(negedge clk);
    while (!giris_hazir && t < 200) begin
      giris_veri = N'($urandom); giris_mod = ~m;
      @(negedge clk);
      t++;
    end
    giris_veri = w; giris_mod = m;
    if (t >= 200) begin
      chk1("push_hazir", giris_hazir, 1'b1);
    end else begin
      @(posedge clk);
      exp_q.push_back({m, w}); lat_q.push_back(l); pushed++;
    end
    #1 giris_gecerli = 1'b0;
    stall = t;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(m_st == M_BOS && exp_q.size() == 0) && t < 400) begin
      @(posedge clk); #1; t++;
    end
    chk1("idle_reached", t < 400, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, h0, st0, st1, t;
    logic [N-1:0] w1, w2;

    // Reset and release
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk1("hazir_pre_edge", giris_hazir, 1'b0);
    idle(1);
    chk1("hazir_after_edge", giris_hazir, 1'b1);

    // Parallel word
    s0 = n_sonuc;
    push(1'b0, 12'h716, 3, st0);
    wait_idle();
    chk("par_sonuc", sonuc, 12'h474);
    chk("par_count", N'(n_sonuc - s0), N'(1));

    // Chunked word
    s0 = n_sonuc;
    push(1'b1, 12'h716, 2, st0);
    wait_idle();
    chk("chunk_sonuc", sonuc, 12'h474);
    chk("chunk_count", N'(n_sonuc - s0), N'(1));

    // Back-to-back with bitti left high across words
    keep_stale = 1'b1;
    s0 = n_sonuc;
    push(1'b0, 12'h01C, 2, st0);
    push(1'b1, 12'hF70, 4, st1);
    chk("b2b_stall0", N'(st0), N'(0));
    chk("b2b_stall1", N'(st1), N'(0));
    wait_idle();
    chk("b2b_sonuc", sonuc, 12'hD8A);
    chk("b2b_count", N'(n_sonuc - s0), N'(2));
    keep_stale = 1'b0;

    // Queue full while a word is in flight
    push(1'b0, N'($urandom), 12, st0);
    idle(3);
    push(1'b1, N'($urandom), 2, st0);
    push(1'b0, N'($urandom), 2, st0);
    chk1("full_hazir", giris_hazir, 1'b0);
    push(1'b1, N'($urandom), 3, st1);
    chk1("full_stalled", st1 > 0, 1'b1);
    wait_idle();

    // Timeout followed by a queued word
    h0 = n_hata; s0 = n_sonuc;
    w1 = N'($urandom); w2 = N'($urandom);
    push(1'b0, w1, 1000, st0);
    push(1'b1, w2, 3, st0);
    wait_idle();
    chk("to_hata_count", N'(n_hata - h0), N'(1));
    chk("to_sonuc_count", N'(n_sonuc - s0), N'(1));
    chk("to_next_sonuc", sonuc, dec_f(w2));

    // Asynchronous reset during the second chunk
    s0 = n_sonuc; h0 = n_hata;
    push(1'b1, N'($urandom), 5, st0);
    t = 0;
    do begin @(negedge clk); #1; t++; end while (!(m_st == M_SEND && chunk == 1) && t < 50);
    chk1("rst_chunk_found", t < 50, 1'b1);
    @(posedge clk); #2;
    chk1("basla_before_rst", basla, 1'b1);
    rst = 1'b0;
    exp_q.delete(); lat_q.delete(); pushed = 0; popped = 0;
    #1;
    chk1("basla_async", basla, 1'b0);
    chk1("sgec_async", sonuc_gecerli, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_no_sonuc", N'(n_sonuc - s0), N'(0));
    chk("rst_no_hata", N'(n_hata - h0), N'(0));
    idle(1);
    push(1'b1, 12'h39C, 4, st0);
    wait_idle();
    chk("post_rst_sonuc", sonuc, 12'h169);

    // Randomized traffic
    s0 = n_sonuc; h0 = n_hata;
    for (int i = 0; i < 25; i++) begin
      keep_stale = 1'($urandom_range(0, 1));
      push(1'($urandom_range(0, 1)), N'($urandom), int'($urandom_range(1, 20)), st0);
      idle(int'($urandom_range(0, 3)));
    end
    wait_idle();
    chk("rand_total", N'((n_sonuc - s0) + (n_hata - h0)), N'(25));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
